result_drain: RTL and testbench

- Downstream consumer of the systolic result shift chain (the row of result-select registers fed by per-PE locals).
- Drives the chain's `ResultCapture` control: one load cycle, then exactly CHAIN_LEN shift cycles.
- Captures each row arriving at the chain tail, applies optional per-lane ReLU, and buffers rows in an output FIFO with a valid/ready interface toward the output buffer writer.

---
 rtl/result_drain.sv | 158 +++++++++++++++
 tb/tb_result_drain.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_drain.sv
// result_drain: consumer at the tail of the systolic result shift chain.
// Sequences one chain load followed by exactly CHAIN_LEN shift cycles,
// applies optional per-lane ReLU to each row leaving the chain and buffers
// the rows in a small FIFO with a valid/ready interface downstream.
module result_drain #(
  parameter int DATA_WIDTH = 8,
  parameter int CHAIN_LEN  = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                      Clk,
  input  logic                      rst,
  input  logic                      drain_start,
  input  logic                      relu_en,
  input  logic [4*DATA_WIDTH-1:0]   ChainIn_0,
  input  logic [4*DATA_WIDTH-1:0]   ChainIn_1,
  input  logic [4*DATA_WIDTH-1:0]   ChainIn_2,
  input  logic [4*DATA_WIDTH-1:0]   ChainIn_3,
  output logic                      ResultCapture,
  output logic                      drain_busy,
  output logic                      drain_done,
  output logic                      err_overrun,
  output logic [16*DATA_WIDTH-1:0]  out_data,
  output logic                      out_valid,
  input  logic                      out_ready
);

  localparam int ROW_W = 16 * DATA_WIDTH;
  localparam int LANES = 16;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int SH_W  = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;

  localparam logic [SH_W-1:0]  SH_LAST   = SH_W'(CHAIN_LEN - 1);
  // A drain may only begin when at most this many entries are occupied,
  // because the chain cannot be paused once it starts shifting.
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(FIFO_DEPTH - CHAIN_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_LOAD,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t                state;
  logic [SH_W-1:0]       shift_cnt;

  logic [ROW_W-1:0]      fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;

  logic [ROW_W-1:0]      raw_row;
  logic [ROW_W-1:0]      relu_row;
  logic                  push;
  logic                  pop;
  logic                  space_ok;

  assign raw_row   = {ChainIn_3, ChainIn_2, ChainIn_1, ChainIn_0};
  assign push      = (state == S_SHIFT);
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign space_ok  = (count <= CNT_LIMIT);
  assign out_data  = fifo_mem[rd_ptr];

  // Zero every lane whose two's-complement sign bit is set when ReLU is on.
  always_comb begin
    relu_row = raw_row;
    for (int i = 0; i < LANES; i++) begin
      if (relu_en && raw_row[i*DATA_WIDTH + DATA_WIDTH - 1]) begin
        relu_row[i*DATA_WIDTH +: DATA_WIDTH] = '0;
      end
    end
  end

  // Drain sequencer with registered control outputs.
  always_ff @(posedge Clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      shift_cnt     <= '0;
      ResultCapture <= 1'b0;
      drain_busy    <= 1'b0;
      drain_done    <= 1'b0;
    end else begin
      drain_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (drain_start) begin
            drain_busy <= 1'b1;
            if (space_ok) state <= S_LOAD;
            else          state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (space_ok) state <= S_LOAD;
        end
        S_LOAD: begin
          state         <= S_SHIFT;
          shift_cnt     <= '0;
          ResultCapture <= 1'b1;
        end
        S_SHIFT: begin
          shift_cnt <= shift_cnt + SH_W'(1);
          if (shift_cnt == SH_LAST) begin
            state         <= S_DONE;
            ResultCapture <= 1'b0;
            drain_busy    <= 1'b0;
            drain_done    <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state         <= S_IDLE;
          ResultCapture <= 1'b0;
          drain_busy    <= 1'b0;
        end
      endcase
    end
  end

  // Sticky flag for a drain request that arrives while a drain is in flight.
  always_ff @(posedge Clk or posedge rst) begin
    if (rst) begin
      err_overrun <= 1'b0;
    end else if (drain_start && (state != S_IDLE)) begin
      err_overrun <= 1'b1;
    end
  end

  // Output FIFO storage and pointers; push and pop may happen together.
  always_ff @(posedge Clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= relu_row;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_result_drain.sv
// tb_result_drain: self-checking bench for result_drain with a behavioural
// model of the result shift chain and a row scoreboard.
module tb_result_drain;

  localparam int DW    = 8;
  localparam int CL    = 4;
  localparam int FD    = 8;
  localparam int ROW_W = 16 * DW;
  localparam int SEG_W = 4 * DW;

  logic              Clk = 1'b0;
  logic              rst = 1'b1;
  logic              drain_start = 1'b0;
  logic              relu_en = 1'b0;
  logic [SEG_W-1:0]  ChainIn_0, ChainIn_1, ChainIn_2, ChainIn_3;
  logic              ResultCapture, drain_busy, drain_done, err_overrun;
  logic [ROW_W-1:0]  out_data;
  logic              out_valid;
  logic              out_ready = 1'b0;

  logic [ROW_W-1:0]  locals [CL];
  logic [ROW_W-1:0]  chain  [CL];
  logic [ROW_W-1:0]  exp_q [$];

  int errors = 0;
  int checks = 0;
  int pops   = 0;
  int dones  = 0;

  typedef struct {
    logic [ROW_W-1:0] row;
    logic             relu;
    logic [ROW_W-1:0] expected;
  } relu_vec_t;

  relu_vec_t relu_tbl [4];

  result_drain #(.DATA_WIDTH(DW), .CHAIN_LEN(CL), .FIFO_DEPTH(FD)) dut (
    .Clk(Clk), .rst(rst), .drain_start(drain_start), .relu_en(relu_en),
    .ChainIn_0(ChainIn_0), .ChainIn_1(ChainIn_1),
    .ChainIn_2(ChainIn_2), .ChainIn_3(ChainIn_3),
    .ResultCapture(ResultCapture), .drain_busy(drain_busy),
    .drain_done(drain_done), .err_overrun(err_overrun),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  // Free-running clock.
  always #5 Clk = ~Clk;

  // Chain model: loads locals while capture is low, shifts toward the tail otherwise.
  always @(posedge Clk) begin
    if (!ResultCapture) begin
      for (int i = 0; i < CL; i++) chain[i] <= locals[i];
    end else begin
      chain[0] <= '0;
      for (int i = 1; i < CL; i++) chain[i] <= chain[i-1];
    end
  end

  assign ChainIn_0 = chain[CL-1][0*SEG_W +: SEG_W];
  assign ChainIn_1 = chain[CL-1][1*SEG_W +: SEG_W];
  assign ChainIn_2 = chain[CL-1][2*SEG_W +: SEG_W];
  assign ChainIn_3 = chain[CL-1][3*SEG_W +: SEG_W];

  function automatic logic [ROW_W-1:0] relu_model(logic [ROW_W-1:0] row, logic en);
    logic [ROW_W-1:0] r;
    logic signed [DW-1:0] lane;
    r = row;
    for (int l = 0; l < 16; l++) begin
      lane = row[l*DW +: DW];
      if (en && lane < 0) r[l*DW +: DW] = '0;
    end
    return r;
  endfunction

  task automatic check_output(string name, logic [ROW_W-1:0] actual, logic [ROW_W-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic randomize_locals();
    for (int s = 0; s < CL; s++)
      for (int w = 0; w < 4; w++) locals[s][w*32 +: 32] = $urandom;
  endtask

  // Pulse drain_start for one edge; an accepted drain enqueues its rows, tail stage first.
  task automatic apply_stimulus(bit expect_accept);
    drain_start = 1'b1;
    if (expect_accept)
      for (int s = CL-1; s >= 0; s--) exp_q.push_back(relu_model(locals[s], relu_en));
    step();
    drain_start = 1'b0;
  endtask

  task automatic wait_done(int budget);
    int n = 0;
    while (!drain_done && n < budget) begin
      step();
      n++;
    end
    if (!drain_done) begin
      checks++;
      errors++;
      $display("[TB] FAIL wait_done: got timeout expected drain_done");
    end
    step();
  endtask

  task automatic flush();
    int n = 0;
    out_ready = 1'b1;
    while (out_valid && n < 40) begin
      step();
      n++;
    end
    out_ready = 1'b0;
    step();
    check_output("flush_empty_valid", out_valid, 1'b0);
    check_output("flush_queue_empty", exp_q.size(), 0);
  endtask

  task automatic basic_drain();
    int p0;
    locals[3] = {16{8'h04}};
    locals[2] = {16{8'h03}};
    locals[1] = {16{8'h02}};
    locals[0] = {16{8'h01}};
    relu_en   = 1'b0;
    out_ready = 1'b1;
    step();
    p0 = pops;
    apply_stimulus(1'b1);
    check_output("load_capture", ResultCapture, 1'b0);
    check_output("load_busy", drain_busy, 1'b1);
    check_output("load_done", drain_done, 1'b0);
    for (int k = 0; k < CL; k++) begin
      step();
      check_output("shift_capture", ResultCapture, 1'b1);
      check_output("shift_busy", drain_busy, 1'b1);
    end
    step();
    check_output("done_pulse", drain_done, 1'b1);
    check_output("done_capture", ResultCapture, 1'b0);
    check_output("done_busy", drain_busy, 1'b0);
    step();
    check_output("done_cleared", drain_done, 1'b0);
    flush();
    check_output("basic_rows", pops - p0, CL);
  endtask

  // Scoreboard monitor: checks each popped row and output stability under stall.
  initial begin
    logic             stall_prev;
    logic [ROW_W-1:0] data_prev;
    stall_prev = 1'b0;
    data_prev  = '0;
    forever begin
      @(negedge Clk);
      if (rst) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          check_output("hold_valid", out_valid, 1'b1);
          check_output("hold_data", out_data, data_prev);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_pop: got %h expected no row", out_data);
          end else begin
            check_output("row_order", out_data, exp_q.pop_front());
          end
          pops++;
        end
        if (drain_done) dones++;
        stall_prev = out_valid && !out_ready;
        data_prev  = out_data;
      end
    end
  end

  // Stimulus sequence.
  initial begin
    int p0, d0, n;

    relu_tbl[0] = '{row: {4{32'h00FF807F}}, relu: 1'b1, expected: {4{32'h0000007F}}};
    relu_tbl[1] = '{row: {4{32'h00FF807F}}, relu: 1'b0, expected: {4{32'h00FF807F}}};
    relu_tbl[2] = '{row: {8{16'h8001}},     relu: 1'b1, expected: {8{16'h0001}}};
    relu_tbl[3] = '{row: {4{32'h817F40C0}}, relu: 1'b1, expected: {4{32'h007F4000}}};

    for (int s = 0; s < CL; s++) locals[s] = '0;

    // Reset state.
    step();
    step();
    check_output("rst_capture", ResultCapture, 1'b0);
    check_output("rst_busy", drain_busy, 1'b0);
    check_output("rst_done", drain_done, 1'b0);
    check_output("rst_overrun", err_overrun, 1'b0);
    check_output("rst_valid", out_valid, 1'b0);
    check_output("rst_data", out_data, '0);
    rst = 1'b0;
    step();

    // Basic drain with timing checks.
    basic_drain();

    // ReLU vector table.
    for (int i = 0; i < 4; i++) begin
      for (int s = 0; s < CL; s++) locals[s] = relu_tbl[i].row;
      relu_en   = relu_tbl[i].relu;
      out_ready = 1'b0;
      apply_stimulus(1'b1);
      wait_done(20);
      check_output("relu_tbl", out_data, relu_tbl[i].expected);
      flush();
    end
    relu_en = 1'b0;

    // Space wait with a full FIFO.
    p0 = pops;
    out_ready = 1'b0;
    randomize_locals();
    apply_stimulus(1'b1);
    wait_done(20);
    randomize_locals();
    apply_stimulus(1'b1);
    wait_done(20);
    check_output("full_valid", out_valid, 1'b1);
    randomize_locals();
    apply_stimulus(1'b1);
    for (int k = 0; k < 3; k++) begin
      step();
      check_output("wait_busy", drain_busy, 1'b1);
      check_output("wait_capture", ResultCapture, 1'b0);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) step();
    out_ready = 1'b0;
    n = 0;
    while (!ResultCapture && n < 10) begin
      step();
      n++;
    end
    check_output("wait_to_shift", ResultCapture, 1'b1);
    wait_done(20);
    flush();
    check_output("wait_rows", pops - p0, 3*CL);

    // Backpressure toggling during SHIFT.
    p0 = pops;
    randomize_locals();
    out_ready = 1'b0;
    apply_stimulus(1'b1);
    step(); out_ready = 1'b1;
    step(); out_ready = 1'b0;
    step(); out_ready = 1'b0;
    step(); out_ready = 1'b1;
    step(); out_ready = 1'b0;
    check_output("bp_done", drain_done, 1'b1);
    check_output("bp_popped", pops - p0, 1);
    flush();
    check_output("bp_rows", pops - p0, CL);

    // Overrun during SHIFT cycle 2.
    p0 = pops;
    d0 = dones;
    randomize_locals();
    out_ready = 1'b1;
    apply_stimulus(1'b1);
    step();
    step();
    step();
    apply_stimulus(1'b0);
    check_output("ovr_flag", err_overrun, 1'b1);
    wait_done(20);
    for (int k = 0; k < 6; k++) step();
    check_output("ovr_one_done", dones - d0, 1);
    check_output("ovr_sticky", err_overrun, 1'b1);
    check_output("ovr_idle", drain_busy, 1'b0);
    flush();
    check_output("ovr_rows", pops - p0, CL);

    // Reset in the middle of SHIFT after two pushes.
    randomize_locals();
    out_ready = 1'b0;
    apply_stimulus(1'b1);
    step();
    step();
    step();
    check_output("mid_valid_before", out_valid, 1'b1);
    rst = 1'b1;
    #1;
    check_output("mid_rst_capture", ResultCapture, 1'b0);
    check_output("mid_rst_valid", out_valid, 1'b0);
    check_output("mid_rst_overrun", err_overrun, 1'b0);
    check_output("mid_rst_busy", drain_busy, 1'b0);
    check_output("mid_rst_data", out_data, '0);
    exp_q.delete();
    step();
    rst = 1'b0;
    step();
    basic_drain();

    // Randomized drains with random backpressure.
    for (int it = 0; it < 15; it++) begin
      n = 0;
      while ((drain_busy || drain_done) && n < 60) begin
        out_ready = 1'($urandom_range(0, 1));
        step();
        n++;
      end
      check_output("rand_idle", drain_busy, 1'b0);
      randomize_locals();
      relu_en = 1'($urandom_range(0, 1));
      apply_stimulus(1'b1);
      n = 0;
      while (!drain_done && n < 100) begin
        out_ready = 1'($urandom_range(0, 1));
        step();
        n++;
      end
      check_output("rand_done", drain_done, 1'b1);
      step();
    end
    flush();
    check_output("final_overrun", err_overrun, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
